// File: rtl/mmio_io_regs.sv
// mmio_io_regs: display-mode flags, debounced sticky button events, registered read port
module mmio_io_regs #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn_raw,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              show_enb,
  input  logic              show_original_enb,
  input  logic              btn_enb,
  input  logic [1:0]        btn_selecc,
  output logic              show,
  output logic              show_original,
  output logic [3:0]        btn_level,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  logic [3:0]        sync1, sync2, s, evt, hit_max, rise, clr_mask;
  logic [CNT_W-1:0]  cnt [4];
  logic              rd_hit, btn_rd;
  logic [DATA_W-1:0] rd_next;
  logic              unused_wdata;
  assign unused_wdata = ^wdata[DATA_W-1:1];
  assign s        = ~sync2;
  assign rd_hit   = rd_en & (show_original_enb | show_enb | btn_enb);
  assign btn_rd   = rd_en & btn_enb & ~show_enb & ~show_original_enb;
  assign clr_mask = btn_rd ? (4'b0001 << btn_selecc) : 4'b0000;
  // counter terminal detect, press edges and the read mux
  always_comb begin
    for (int i = 0; i < 4; i++) hit_max[i] = cnt[i] == CNT_MAX;
    rise = s & ~btn_level & hit_max;
    rd_next = '0;
    rd_next[1:0] = show_original_enb ? {1'b0, show_original} :
                   show_enb          ? {1'b0, show} :
                                       {btn_level[btn_selecc], evt[btn_selecc]};
  end
  // synchronize, debounce and capture press events; a coinciding press beats the clearing read
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= '1;
      sync2     <= '1;
      btn_level <= '0;
      evt       <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      evt   <= (evt & ~clr_mask) | rise;
      for (int i = 0; i < 4; i++) begin
        if (s[i] == btn_level[i]) cnt[i] <= '0;
        else if (hit_max[i]) begin
          btn_level[i] <= ~btn_level[i];
          cnt[i]       <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // CPU writes to the display flags; the button window is read-only
  always_ff @(posedge clk) begin
    if (!rst) begin
      show          <= 1'b0;
      show_original <= 1'b0;
    end else if (wr_en) begin
      if (show_original_enb) show_original <= wdata[0];
      else if (show_enb) show <= wdata[0];
    end
  end
  // one-cycle read latency; rd_data holds when no register is hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) rd_data <= rd_next;
    end
  end
endmodule
